// File: rtl/expand_stream.sv
// expand_stream: loads a valid/ready stream of complex words into a banked
// FFT memory, either in natural slot order (direct) or as canonical-embedding
// pairs z / conj(z) walked along the orbit of GEN modulo M = 2N (expand).
//
// Handshake: a beat is accepted on a rising clk edge when in_valid && in_ready.
// in_ready is high exactly while the FSM is in RUN and depends only on the
// state register, never on in_valid. The producer may raise or drop in_valid
// at any time; words offered outside RUN are simply not taken.
module expand_stream #(
    parameter int LOGN      = 13,
    parameter int LOGB      = 1,
    parameter int COEF_W    = 32,
    parameter int GEN       = 3,
    parameter int CONJ_MODE = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               mode,
    input  logic [2*COEF_W-1:0]                in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [(1<<LOGB)-1:0]               wr_en,
    output logic [(1<<LOGB)*(LOGN-LOGB)-1:0]   wr_addr,
    output logic [(1<<LOGB)*2*COEF_W-1:0]      wr_data,
    output logic                               busy,
    output logic                               done
);

    localparam int B  = 1 << LOGB;
    localparam int AW = LOGN - LOGB;
    localparam int DW = 2 * COEF_W;
    localparam int PW = LOGN + 1;

    localparam logic [LOGN-1:0]   LAST_D  = '1;          // N-1
    localparam logic [LOGN-1:0]   LAST_E  = LAST_D >> 1; // N/2-1
    localparam logic [COEF_W-1:0] IM_MSB  = {1'b1, {(COEF_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FSM state is kept as a named enum so checkers can bind to it directly.
    state_t          state, state_next;
    logic [PW-1:0]   pos, pos_next, pos_mul;
    logic [LOGN-1:0] beat, beat_next;
    logic            mode_q, mode_next;

    logic            accept;
    logic            last_beat;

    logic [LOGN-1:0]   j, i0, i1;
    logic [COEF_W-1:0] re, im, im_c;
    logic [DW-1:0]     conj_data;

    logic [B-1:0]      en_next;
    logic [B*AW-1:0]   addr_next;
    logic [B*DW-1:0]   data_next;

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_beat = mode_q ? (beat == LAST_E) : (beat == LAST_D);

    // Orbit step pos*GEN mod 2N; GEN=3 reduces to a shift-add.
    generate
        if (GEN == 3) begin : g_mul3
            assign pos_mul = (pos << 1) + pos;
        end else begin : g_mulk
            localparam logic [PW-1:0] GEN_C = PW'(GEN);
            assign pos_mul = pos * GEN_C;
        end
    endgenerate

    // pos is always odd, so (pos-1)>>1 is just the upper LOGN bits of pos.
    assign j = pos[LOGN:1];

    // Bit-reverse j to get the embedding slot; the mirror slot is its complement.
    always_comb begin
        i0 = '0;
        for (int n = 0; n < LOGN; n++) begin
            i0[n] = j[LOGN-1-n];
        end
        i1 = ~i0;
    end

    // Conjugate: real part passes, imaginary part is sign-flipped per CONJ_MODE.
    assign re        = in_data[DW-1:COEF_W];
    assign im        = in_data[COEF_W-1:0];
    assign im_c      = (CONJ_MODE != 0) ? (COEF_W'(0) - im) : (im ^ IM_MSB);
    assign conj_data = {re, im_c};

    // Next-state logic for the job FSM, orbit position and beat counter.
    always_comb begin
        state_next = state;
        pos_next   = pos;
        beat_next  = beat;
        mode_next  = mode_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    mode_next  = mode;
                    pos_next   = PW'(1);
                    beat_next  = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    beat_next = beat + LOGN'(1);
                    if (mode_q) begin
                        pos_next = pos_mul;
                    end
                    if (last_beat) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bank write decode: address/data hold unless the bank is written.
    always_comb begin
        en_next   = '0;
        addr_next = wr_addr;
        data_next = wr_data;
        if (accept) begin
            if (mode_q) begin
                en_next[i0[LOGB-1:0]]                         = 1'b1;
                addr_next[int'(i0[LOGB-1:0])*AW +: AW]        = i0[LOGN-1:LOGB];
                data_next[int'(i0[LOGB-1:0])*DW +: DW]        = in_data;
                en_next[i1[LOGB-1:0]]                         = 1'b1;
                addr_next[int'(i1[LOGB-1:0])*AW +: AW]        = i1[LOGN-1:LOGB];
                data_next[int'(i1[LOGB-1:0])*DW +: DW]        = conj_data;
            end else begin
                en_next[beat[LOGB-1:0]]                       = 1'b1;
                addr_next[int'(beat[LOGB-1:0])*AW +: AW]      = beat[LOGN-1:LOGB];
                data_next[int'(beat[LOGB-1:0])*DW +: DW]      = in_data;
            end
        end
    end

    // State and registered bank outputs; reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pos     <= PW'(1);
            beat    <= '0;
            mode_q  <= 1'b0;
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_next;
            pos     <= pos_next;
            beat    <= beat_next;
            mode_q  <= mode_next;
            wr_en   <= en_next;
            wr_addr <= addr_next;
            wr_data <= data_next;
        end
    end

endmodule
